jtframe_68kbusrq: RTL and testbench
===================================

JTFRAME_68KBUSRQ -- requirements
Module: jtframe_68kbusrq

Interface
REQ-001 SHALL have parameter AW, default 23: width of the word address.
REQ-002 SHALL have parameter LW, default 3: width of the legitimate wait-state count.
REQ-003 SHALL have port rst  input  1: reset; asynchronous, active-high.
REQ-004 SHALL have port clk  input  1: system clock.
REQ-005 SHALL have port cpu_cen  input  1: CPU clock enable, from the DTACK generator.
REQ-006 SHALL have port ASn, UDSn, LDSn, RnW  input  1 each: 68000 bus strobes.
REQ-007 SHALL have port addr  input  AW: CPU word address.
REQ-008 SHALL have port cpu_dout  input  16: CPU write data.
REQ-009 SHALL have port cs  input  1: region select from the address decoder.
REQ-010 SHALL have port legit_wait  input  LW: original-hardware wait states for the selected region.
REQ-011 SHALL have port cpu_din  output  16: read data latched for the CPU.
REQ-012 SHALL have port mem_cs, mem_we  output  1 each: memory request and write flag.
REQ-013 SHALL have port mem_addr  output  AW; mem_din  output  16; mem_dsn  output  2 ({UDSn,LDSn}).
REQ-014 SHALL have port mem_ok  input  1; mem_dout  input  16: memory acknowledge and read data.
REQ-015 SHALL have port bus_cs, bus_busy, bus_legit  output  1 each: status to the DTACK generator.

Function
REQ-016 SHALL derive BUSn = ASn | (UDSn & LDSn).
REQ-017 SHALL drive bus_cs = cs & ~BUSn, combinationally.
REQ-018 SHALL implement FSM IDLE, REQ, DONE.
REQ-019 SHALL, in IDLE with bus_cs=1, latch addr, cpu_dout, {UDSn,LDSn} and ~RnW into mem_addr, mem_din, mem_dsn and mem_we; set mem_cs=1; load the legit counter with legit_wait; go to REQ.
REQ-020 SHALL ignore mem_ok in the first cycle of REQ and sample it from the second cycle on.
REQ-021 SHALL, on a sampled mem_ok in REQ: clear mem_cs; latch mem_dout into cpu_din when mem_we=0, otherwise leave cpu_din unchanged; go to DONE.
REQ-022 SHALL decrement the legit counter on each cpu_cen while it is non-zero and the state is not IDLE, saturating at 0.
REQ-023 SHALL drive bus_busy = bus_cs & ~(state==DONE & cnt==0), so it is high in the first cycle the strobes fall.
REQ-024 SHALL drive bus_legit = bus_cs & (cnt!=0), and bus_legit = 0 while mem_ok is outstanding with cnt==0.
REQ-025 SHALL hold DONE until BUSn=1, then return to IDLE. A read-modify-write therefore issues two requests, separated by the BUSn pulse.
REQ-026 SHALL, when BUSn rises during REQ (aborted cycle), keep mem_cs high until mem_ok, then go to IDLE directly, and SHALL NOT accept a new cycle before that.
REQ-027 SHALL keep mem_* stable while mem_cs=1.
REQ-028 SHALL issue no request and hold its state when cs=0 with BUSn=0.
REQ-029 SHALL take cs and legit_wait only from the IDLE-to-REQ cycle; later changes SHALL be ignored.

Reset
REQ-030 SHALL, on rst, set state=IDLE, mem_cs=0, mem_we=0, mem_dsn=2'b11, mem_addr=0, mem_din=0, cpu_din=0 and cnt=0.
REQ-031 SHALL, when rst is asserted mid-request, drop mem_cs immediately; the memory controller tolerates the abandoned request.

Structure
REQ-032 SHALL be a single module with no sub-modules and no package; the state encoding SHALL be localparams.
REQ-033 SHALL contain sequential logic on clk with async rst only.

Verification
REQ-034 Read, cs=1, legit_wait=0, mem_ok 4 cycles after mem_cs, mem_dout=16'hA55A -> bus_busy high for 5 cycles, cpu_din=16'hA55A, mem_we=0.
REQ-035 Byte write, UDSn=1, LDSn=0, cpu_dout=16'h0012 -> mem_dsn=2'b10, mem_we=1, mem_din=16'h0012, cpu_din unchanged.
REQ-036 legit_wait=3, mem_ok after 1 cycle -> bus_busy and bus_legit stay high until the 3rd cpu_cen, then both drop.
REQ-037 RMW (read, then BUSn=1 for 2 cycles, then write) -> two mem_cs pulses; the second has mem_we=1.
REQ-038 BUSn rises before mem_ok -> mem_cs is held until mem_ok; a new strobe fall meanwhile produces no second request until IDLE.
REQ-039 rst pulse during REQ -> mem_cs=0 in the next cycle, all outputs at reset values, and the next cycle is serviced normally.

Source files
------------

// File: rtl/jtframe_68kbusrq.sv
// 68000 bus-to-memory request bridge: turns one strobed CPU cycle into one memory
// request and tells the DTACK generator when the cycle may finish.
`timescale 1ns/1ps
module jtframe_68kbusrq #(
    parameter int AW = 23,
    parameter int LW = 3
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cpu_cen,
    input  logic          ASn,
    input  logic          UDSn,
    input  logic          LDSn,
    input  logic          RnW,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   cpu_dout,
    input  logic          cs,
    input  logic [LW-1:0] legit_wait,
    output logic [15:0]   cpu_din,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_dsn,
    input  logic          mem_ok,
    input  logic [15:0]   mem_dout,
    output logic          bus_cs,
    output logic          bus_busy,
    output logic          bus_legit
);
    localparam logic [1:0]    ST_IDLE = 2'd0;
    localparam logic [1:0]    ST_REQ  = 2'd1;
    localparam logic [1:0]    ST_DONE = 2'd2;
    localparam logic [LW-1:0] CNT_ONE = LW'(1);

    logic [1:0]    r_state;
    logic [LW-1:0] r_cnt;
    logic          r_first;   // mem_ok may still be left over from the previous request
    logic          r_abort;   // strobes went away before the memory answered
    logic          w_busn;

    assign w_busn    = ASn | (UDSn & LDSn);
    assign bus_cs    = cs & ~w_busn;
    assign bus_busy  = bus_cs & ~(r_state == ST_DONE && r_cnt == '0);
    assign bus_legit = bus_cs & (r_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_first  <= 1'b0;
            r_abort  <= 1'b0;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_dsn  <= 2'b11;
            mem_addr <= '0;
            mem_din  <= '0;
            cpu_din  <= '0;
        end else begin
            if (r_state != ST_IDLE && cpu_cen && r_cnt != '0)
                r_cnt <= r_cnt - CNT_ONE;
            case (r_state)
                ST_IDLE: begin
                    if (bus_cs) begin
                        mem_addr <= addr;
                        mem_din  <= cpu_dout;
                        mem_dsn  <= {UDSn, LDSn};
                        mem_we   <= ~RnW;
                        mem_cs   <= 1'b1;
                        r_cnt    <= legit_wait;
                        r_first  <= 1'b1;
                        r_abort  <= 1'b0;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_first <= 1'b0;
                    if (w_busn)
                        r_abort <= 1'b1;
                    if (mem_ok && !r_first) begin
                        mem_cs <= 1'b0;
                        if (!mem_we)
                            cpu_din <= mem_dout;
                        // an abandoned cycle skips DONE so the next strobe is serviced at once
                        r_state <= r_abort ? ST_IDLE : ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_busn)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_68kbusrq.sv
// Bench for jtframe_68kbusrq: a latency-programmable memory responder, a transaction
// model checked every cycle, and directed bus cycles with literal expectations.
`timescale 1ns/1ps
module tb_jtframe_68kbusrq;
    localparam int AW = 23;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_cen = 1'b1;
    logic          ASn = 1'b1, UDSn = 1'b1, LDSn = 1'b1, RnW = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [15:0]   cpu_dout = '0;
    logic          cs = 1'b0;
    logic [LW-1:0] legit_wait = '0;
    logic [15:0]   cpu_din;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_dsn;
    logic          mem_ok = 1'b0;
    logic [15:0]   mem_dout = '0;
    logic          bus_cs, bus_busy, bus_legit;

    jtframe_68kbusrq #(.AW(AW), .LW(LW)) dut (
        .rst(rst), .clk(clk), .cpu_cen(cpu_cen),
        .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RnW(RnW),
        .addr(addr), .cpu_dout(cpu_dout), .cs(cs), .legit_wait(legit_wait),
        .cpu_din(cpu_din), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dsn(mem_dsn),
        .mem_ok(mem_ok), .mem_dout(mem_dout),
        .bus_cs(bus_cs), .bus_busy(bus_busy), .bus_legit(bus_legit)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Memory responder: mem_ok rises once mem_cs has been seen for lat cycles, held until mem_cs drops
    logic [15:0] mem_arr [16];
    int lat = 2;
    int rcnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_cs) begin
            rcnt++;
            mem_ok = (rcnt >= lat);
        end else begin
            rcnt = 0;
            mem_ok = 1'b0;
        end
        mem_dout = mem_arr[mem_addr[3:0]];
    end

    int cen_every = 1;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        #2;
        cyc++;
        cpu_cen = ((cyc % cen_every) == 0);
    end

    // Transaction model: phase 0 = no cycle, 1 = request outstanding, 2 = data delivered
    logic t_busn, t_bcs;
    assign t_busn = ASn | (UDSn & LDSn);
    assign t_bcs  = cs & ~t_busn;

    int            m_phase;
    logic          m_first, m_abort, m_we;
    int            m_rem;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_wdata, m_rdata;
    logic [1:0]    m_dsn;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_first <= 1'b0; m_abort <= 1'b0; m_rem <= 0;
            m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_dsn <= 2'b11; m_we <= 1'b0;
        end else begin
            if (m_phase != 0 && cpu_cen && m_rem > 0)
                m_rem <= m_rem - 1;
            case (m_phase)
                0: if (t_bcs) begin
                    m_addr <= addr; m_wdata <= cpu_dout; m_dsn <= {UDSn, LDSn};
                    m_we <= ~RnW; m_rem <= int'(legit_wait);
                    m_phase <= 1; m_first <= 1'b1; m_abort <= 1'b0;
                end
                1: begin
                    if (mem_ok && !m_first) begin
                        if (!m_we) m_rdata <= mem_dout;
                        m_phase <= m_abort ? 0 : 2;
                    end
                    if (t_busn) m_abort <= 1'b1;
                    m_first <= 1'b0;
                end
                default: if (t_busn) m_phase <= 0;
            endcase
        end
    end

    logic    cmp_en = 1'b0;
    logic    prev_cs = 1'b0;
    int      rises = 0;
    logic    l_we;
    logic [1:0]  l_dsn;
    logic [15:0] l_din;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bus_cs", bus_cs, t_bcs);
            chk("bus_busy", bus_busy, t_bcs & !(m_phase == 2 && m_rem == 0));
            chk("bus_legit", bus_legit, t_bcs & (m_rem != 0));
            chk("mem_cs", mem_cs, m_phase == 1);
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_din", mem_din, m_wdata);
            chk("mem_dsn", mem_dsn, m_dsn);
            chk("cpu_din", cpu_din, m_rdata);
        end
        if (mem_cs && !prev_cs) begin
            rises++;
            l_we = mem_we; l_dsn = mem_dsn; l_din = mem_din;
        end
        prev_cs = mem_cs;
    end

    task automatic strobe(input logic [AW-1:0] a, input logic [15:0] d, input logic u,
                          input logic l, input logic rnw, input logic [LW-1:0] lw);
        @(posedge clk);
        #2;
        addr = a; cpu_dout = d; UDSn = u; LDSn = l; RnW = rnw;
        cs = 1'b1; legit_wait = lw; ASn = 1'b0;
    endtask

    task automatic wait_done(output int nb, output int nl);
        nb = 0; nl = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_busy) nb++;
            if (bus_legit) nl++;
            if (!bus_busy) return;
        end
        chk("busy_timeout", 1, 0);
    endtask

    task automatic release_bus(input int gap);
        @(posedge clk);
        #2;
        ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        repeat (gap - 1) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nl, r0;
        for (int i = 0; i < 16; i++)
            mem_arr[i] = 16'hA55A ^ 16'(i * 16'h0101);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_dsn", mem_dsn, 2'b11);
        chk("rst_cpu_din", cpu_din, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        // plain read, four-cycle memory
        lat = 4;
        strobe(0, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        wait_done(nb, nl);
        chk("rd_busy_cycles", nb, 5);
        chk("rd_cpu_din", cpu_din, 16'hA55A);
        chk("rd_we", l_we, 0);
        release_bus(2);

        // lower-byte write
        lat = 3;
        strobe(5, 16'h0012, 1'b1, 1'b0, 1'b0, 0);
        wait_done(nb, nl);
        chk("wr_dsn", l_dsn, 2'b10);
        chk("wr_we", l_we, 1);
        chk("wr_din", l_din, 16'h0012);
        chk("wr_cpu_din_kept", cpu_din, 16'hA55A);
        release_bus(2);

        // legitimate wait of 3 with an early mem_ok that must be ignored in the first cycle
        lat = 1;
        strobe(3, 16'h0000, 1'b0, 1'b0, 1'b1, 3);
        wait_done(nb, nl);
        chk("legit_busy_cycles", nb, 4);
        chk("legit_cycles", nl, 3);
        chk("legit_cpu_din", cpu_din, 16'hA659);
        release_bus(2);

        // read-modify-write
        r0 = rises;
        lat = 2;
        strobe(2, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        wait_done(nb, nl);
        release_bus(2);
        strobe(2, 16'hBEEF, 1'b0, 1'b0, 1'b0, 0);
        wait_done(nb, nl);
        chk("rmw_requests", rises - r0, 2);
        chk("rmw_second_we", l_we, 1);
        release_bus(2);

        // cs and legit_wait changing after the request starts
        r0 = rises;
        cen_every = 2;
        lat = 3;
        strobe(7, 16'h1234, 1'b0, 1'b1, 1'b0, 2);
        @(posedge clk);
        #2 legit_wait = 7; cs = 1'b0;
        @(posedge clk);
        #2 cs = 1'b1;
        wait_done(nb, nl);
        chk("late_change_requests", rises - r0, 1);
        release_bus(2);
        cen_every = 1;

        // aborted read followed by a write strobe while the read is outstanding
        r0 = rises;
        lat = 6;
        strobe(4, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        strobe(4, 16'h5678, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("abort_no_second_yet", rises - r0, 1);
        chk("abort_mem_cs_held", mem_cs, 1);
        wait_done(nb, nl);
        chk("abort_requests", rises - r0, 2);
        chk("abort_second_we", l_we, 1);
        release_bus(2);

        // reset in the middle of a request
        r0 = rises;
        strobe(1, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_mem_cs", mem_cs, 0);
        chk("midrst_mem_dsn", mem_dsn, 2'b11);
        chk("midrst_cpu_din", cpu_din, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        wait_done(nb, nl);
        chk("midrst_requests", rises - r0, 2);
        chk("midrst_cpu_din_after", cpu_din, 16'hA45B);
        release_bus(2);

        // strobes with cs low
        r0 = rises;
        @(posedge clk);
        #2 cs = 1'b0; RnW = 1'b1; UDSn = 1'b0; LDSn = 1'b0; ASn = 1'b0;
        repeat (5) @(negedge clk);
        chk("nocs_requests", rises - r0, 0);
        chk("nocs_busy", bus_busy, 0);
        release_bus(2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
